// File: rtl/adder_scoreboard_pkg.sv
// Shared types and helpers for the adder checker and its stimulus generators.
package adder_tb_pkg;

  typedef enum logic [1:0] {
    SCB_IDLE   = 2'd0,
    SCB_RUN    = 2'd1,
    SCB_DRAIN  = 2'd2,
    SCB_REPORT = 2'd3
  } scb_state_t;

  localparam int SCB_MAX_LATENCY = 16;
  // Operand width the golden model is evaluated at; callers zero-extend and truncate.
  localparam int SCB_GS_WIDTH    = 32;

  function automatic logic [SCB_GS_WIDTH:0] golden_sum(input logic [SCB_GS_WIDTH-1:0] a,
                                                       input logic [SCB_GS_WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/adder_scoreboard_if.sv
// Stimulus/result bundle between the stimulus master and the adder scoreboard.
interface adder_scoreboard_if #(
  parameter int data_width = 8,
  parameter int cnt_width  = 16
);
  logic                  in_valid;
  logic [data_width-1:0] reg_a;
  logic [data_width-1:0] reg_b;
  logic                  stim_done;
  logic [data_width:0]   inp;
  logic                  mismatch;
  logic [cnt_width-1:0]  pass_count;
  logic [cnt_width-1:0]  err_count;
  logic [data_width-1:0] fail_a;
  logic [data_width-1:0] fail_b;
  logic [data_width:0]   fail_got;
  logic                  fail_valid;
  logic                  done;

  modport master (
    output in_valid, reg_a, reg_b, stim_done, inp,
    input  mismatch, pass_count, err_count, fail_a, fail_b, fail_got, fail_valid, done
  );

  modport slave (
    input  in_valid, reg_a, reg_b, stim_done, inp,
    output mismatch, pass_count, err_count, fail_a, fail_b, fail_got, fail_valid, done
  );
endinterface

// File: rtl/adder_scoreboard_sum_delay_line.sv
// Shift register of {v,a,b,exp} matching the adder latency; any_valid drives drain detection.
module sum_delay_line #(
  parameter int data_width = 8,
  parameter int latency    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_v,
  input  logic [data_width-1:0] i_a,
  input  logic [data_width-1:0] i_b,
  input  logic [data_width:0]   i_exp,
  output logic                  o_v,
  output logic [data_width-1:0] o_a,
  output logic [data_width-1:0] o_b,
  output logic [data_width:0]   o_exp,
  output logic                  o_any_valid
);

  logic [latency-1:0]    r_v;
  logic [data_width-1:0] r_a   [latency];
  logic [data_width-1:0] r_b   [latency];
  logic [data_width:0]   r_exp [latency];

  // Stage 0 loads every cycle; later stages shift toward the compare slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      for (int i = 0; i < latency; i++) begin
        r_a[i]   <= '0;
        r_b[i]   <= '0;
        r_exp[i] <= '0;
      end
    end else begin
      r_v[0]   <= i_v;
      r_a[0]   <= i_a;
      r_b[0]   <= i_b;
      r_exp[0] <= i_exp;
      for (int i = 1; i < latency; i++) begin
        r_v[i]   <= r_v[i-1];
        r_a[i]   <= r_a[i-1];
        r_b[i]   <= r_b[i-1];
        r_exp[i] <= r_exp[i-1];
      end
    end
  end

  assign o_v         = r_v[latency-1];
  assign o_a         = r_a[latency-1];
  assign o_b         = r_b[latency-1];
  assign o_exp       = r_exp[latency-1];
  assign o_any_valid = |r_v;

endmodule

// File: rtl/adder_scoreboard.sv
// Adder result checker: golden sum, latency-matched compare, saturating counts, first-failure capture.
// Optional console logging of mismatches and the final report under `define ADDER_SCB_LOG_EN.
module adder_scoreboard
  import adder_tb_pkg::*;
#(
  parameter int data_width = 8,
  parameter int latency    = 1,
  parameter int cnt_width  = 16
) (
  input logic               clk,
  input logic               rst,
  adder_scoreboard_if.slave scb
);

  // Out-of-range latency is clamped so the delay line is always well formed.
  localparam int LAT_EFF = (latency < 1) ? 1 :
                           ((latency > SCB_MAX_LATENCY) ? SCB_MAX_LATENCY : latency);
  localparam logic [cnt_width-1:0] CNT_MAX = {cnt_width{1'b1}};

  scb_state_t            r_state;
  logic                  r_mismatch;
  logic [cnt_width-1:0]  r_pass_count;
  logic [cnt_width-1:0]  r_err_count;
  logic [data_width-1:0] r_fail_a;
  logic [data_width-1:0] r_fail_b;
  logic [data_width:0]   r_fail_got;
  logic                  r_fail_valid;
  logic                  r_done;

  logic                  w_accept;
  logic [data_width:0]   w_exp;
  logic                  w_cmp_v;
  logic [data_width-1:0] w_cmp_a;
  logic [data_width-1:0] w_cmp_b;
  logic [data_width:0]   w_cmp_exp;
  logic                  w_any_valid;
  logic                  w_cmp_ok;

  assign w_accept = (r_state == SCB_IDLE) || (r_state == SCB_RUN);
  assign w_exp    = (data_width+1)'(golden_sum(SCB_GS_WIDTH'(scb.reg_a), SCB_GS_WIDTH'(scb.reg_b)));
  assign w_cmp_ok = (w_cmp_exp == scb.inp);

  sum_delay_line #(
    .data_width (data_width),
    .latency    (LAT_EFF)
  ) u_delay (
    .clk         (clk),
    .rst         (rst),
    .i_v         (scb.in_valid & w_accept),
    .i_a         (scb.reg_a),
    .i_b         (scb.reg_b),
    .i_exp       (w_exp),
    .o_v         (w_cmp_v),
    .o_a         (w_cmp_a),
    .o_b         (w_cmp_b),
    .o_exp       (w_cmp_exp),
    .o_any_valid (w_any_valid)
  );

  // Compare slot, counters, first-failure capture and the run/drain/report FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= SCB_IDLE;
      r_mismatch   <= 1'b0;
      r_pass_count <= '0;
      r_err_count  <= '0;
      r_fail_a     <= '0;
      r_fail_b     <= '0;
      r_fail_got   <= '0;
      r_fail_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_mismatch <= 1'b0;
      if (w_cmp_v) begin
        if (w_cmp_ok) begin
          if (r_pass_count != CNT_MAX) begin
            r_pass_count <= r_pass_count + cnt_width'(1);
          end
        end else begin
          r_mismatch <= 1'b1;
          if (r_err_count != CNT_MAX) begin
            r_err_count <= r_err_count + cnt_width'(1);
          end
          if (!r_fail_valid) begin
            r_fail_a     <= w_cmp_a;
            r_fail_b     <= w_cmp_b;
            r_fail_got   <= scb.inp;
            r_fail_valid <= 1'b1;
          end
        end
      end

      // stim_done wins in IDLE so a vector arriving with it is accepted and then drained.
      case (r_state)
        SCB_IDLE: begin
          if (scb.stim_done) begin
            r_state <= SCB_DRAIN;
          end else if (scb.in_valid) begin
            r_state <= SCB_RUN;
          end
        end
        SCB_RUN: begin
          if (scb.stim_done) begin
            r_state <= SCB_DRAIN;
          end
        end
        SCB_DRAIN: begin
          if (!w_any_valid) begin
            r_state <= SCB_REPORT;
            r_done  <= 1'b1;
          end
        end
        SCB_REPORT: begin
          r_done <= 1'b1;
        end
        default: begin
          r_state <= SCB_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADDER_SCB_LOG_EN
  // Console log of each mismatch and of the final tally.
  always_ff @(posedge clk) begin
    if (!rst && w_cmp_v && !w_cmp_ok) begin
      $display("%t MISMATCH a=%d b=%d exp=%d got=%d", $time, w_cmp_a, w_cmp_b, w_cmp_exp, scb.inp);
    end
    if (!rst && (r_state == SCB_DRAIN) && !w_any_valid) begin
      $display("%t adder_scoreboard report: pass=%0d err=%0d", $time, r_pass_count, r_err_count);
    end
  end
`endif

  assign scb.mismatch   = r_mismatch;
  assign scb.pass_count = r_pass_count;
  assign scb.err_count  = r_err_count;
  assign scb.fail_a     = r_fail_a;
  assign scb.fail_b     = r_fail_b;
  assign scb.fail_got   = r_fail_got;
  assign scb.fail_valid = r_fail_valid;
  assign scb.done       = r_done;

endmodule

// File: tb/tb_adder_scoreboard.sv
// Directed bench for adder_scoreboard: four instances cover latency 1/2/3 and a 3-bit counter.
module tb_adder_scoreboard;

  logic clk = 1'b0;
  logic rst_l1 = 1'b1;
  logic rst_l2 = 1'b1;
  logic rst_c3 = 1'b1;
  logic rst_l3 = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  adder_scoreboard_if #(.data_width(8), .cnt_width(16)) if_l1 ();
  adder_scoreboard_if #(.data_width(8), .cnt_width(16)) if_l2 ();
  adder_scoreboard_if #(.data_width(8), .cnt_width(3))  if_c3 ();
  adder_scoreboard_if #(.data_width(8), .cnt_width(16)) if_l3 ();

  adder_scoreboard #(.data_width(8), .latency(1), .cnt_width(16)) u_l1 (.clk(clk), .rst(rst_l1), .scb(if_l1));
  adder_scoreboard #(.data_width(8), .latency(2), .cnt_width(16)) u_l2 (.clk(clk), .rst(rst_l2), .scb(if_l2));
  adder_scoreboard #(.data_width(8), .latency(1), .cnt_width(3))  u_c3 (.clk(clk), .rst(rst_c3), .scb(if_c3));
  adder_scoreboard #(.data_width(8), .latency(3), .cnt_width(16)) u_l3 (.clk(clk), .rst(rst_l3), .scb(if_l3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Advance past the next rising edge; inputs set afterwards apply to the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    if_l1.in_valid = 1'b0; if_l1.reg_a = 8'd0; if_l1.reg_b = 8'd0; if_l1.stim_done = 1'b0; if_l1.inp = 9'd0;
    if_l2.in_valid = 1'b0; if_l2.reg_a = 8'd0; if_l2.reg_b = 8'd0; if_l2.stim_done = 1'b0; if_l2.inp = 9'd0;
    if_c3.in_valid = 1'b0; if_c3.reg_a = 8'd0; if_c3.reg_b = 8'd0; if_c3.stim_done = 1'b0; if_c3.inp = 9'd0;
    if_l3.in_valid = 1'b0; if_l3.reg_a = 8'd0; if_l3.reg_b = 8'd0; if_l3.stim_done = 1'b0; if_l3.inp = 9'd0;
    step(); step();
    check("rst_pass", 32'(if_l1.pass_count), 32'd0);
    check("rst_err", 32'(if_l1.err_count), 32'd0);
    check("rst_done", 32'(if_l1.done), 32'd0);
    check("rst_fail_valid", 32'(if_l1.fail_valid), 32'd0);
    rst_l1 = 1'b0; rst_l2 = 1'b0; rst_c3 = 1'b0; rst_l3 = 1'b0;

    // Test 1: 200+100=300 passes
    if_l1.in_valid = 1'b1; if_l1.reg_a = 8'd200; if_l1.reg_b = 8'd100;
    step();
    if_l1.in_valid = 1'b0; if_l1.inp = 9'd300;
    check("t1_mm_e1", 32'(if_l1.mismatch), 32'd0);
    step();
    check("t1_pass", 32'(if_l1.pass_count), 32'd1);
    check("t1_err", 32'(if_l1.err_count), 32'd0);
    check("t1_mm_e2", 32'(if_l1.mismatch), 32'd0);
    step();
    check("t1_mm_e3", 32'(if_l1.mismatch), 32'd0);

    // Test 2: 255+255 expects 510, DUT says 509
    rst_l1 = 1'b1; step(); rst_l1 = 1'b0;
    if_l1.in_valid = 1'b1; if_l1.reg_a = 8'd255; if_l1.reg_b = 8'd255; if_l1.inp = 9'd0;
    step();
    if_l1.in_valid = 1'b0; if_l1.inp = 9'd509;
    step();
    check("t2_mm", 32'(if_l1.mismatch), 32'd1);
    check("t2_err", 32'(if_l1.err_count), 32'd1);
    check("t2_pass", 32'(if_l1.pass_count), 32'd0);
    check("t2_fail_a", 32'(if_l1.fail_a), 32'd255);
    check("t2_fail_b", 32'(if_l1.fail_b), 32'd255);
    check("t2_fail_got", 32'(if_l1.fail_got), 32'd509);
    check("t2_fail_valid", 32'(if_l1.fail_valid), 32'd1);
    step();
    check("t2_mm_pulse", 32'(if_l1.mismatch), 32'd0);

    // Test 3: two failures, first is retained
    rst_l1 = 1'b1; step(); rst_l1 = 1'b0;
    if_l1.in_valid = 1'b1; if_l1.reg_a = 8'd1; if_l1.reg_b = 8'd1; if_l1.inp = 9'd0;
    step();
    if_l1.reg_a = 8'd4; if_l1.reg_b = 8'd4; if_l1.inp = 9'd3;
    step();
    if_l1.in_valid = 1'b0; if_l1.inp = 9'd0;
    step();
    check("t3_err", 32'(if_l1.err_count), 32'd2);
    check("t3_mm2", 32'(if_l1.mismatch), 32'd1);
    check("t3_fail_a", 32'(if_l1.fail_a), 32'd1);
    check("t3_fail_b", 32'(if_l1.fail_b), 32'd1);
    check("t3_fail_got", 32'(if_l1.fail_got), 32'd3);

    // Test 4: latency 2, drain and done
    if_l2.in_valid = 1'b1; if_l2.reg_a = 8'd10; if_l2.reg_b = 8'd20;
    step();
    if_l2.reg_a = 8'd30; if_l2.reg_b = 8'd40; if_l2.stim_done = 1'b1;
    step();
    if_l2.reg_a = 8'd7; if_l2.reg_b = 8'd7; if_l2.stim_done = 1'b0; if_l2.inp = 9'd30;
    step();
    check("t4_pass_e3", 32'(if_l2.pass_count), 32'd1);
    if_l2.in_valid = 1'b0; if_l2.inp = 9'd70;
    step();
    check("t4_pass_e4", 32'(if_l2.pass_count), 32'd2);
    check("t4_done_e4", 32'(if_l2.done), 32'd0);
    step();
    check("t4_done_e5", 32'(if_l2.done), 32'd1);
    check("t4_pass_e5", 32'(if_l2.pass_count), 32'd2);
    check("t4_err_e5", 32'(if_l2.err_count), 32'd0);
    step();
    check("t4_done_sticky", 32'(if_l2.done), 32'd1);

    // Test 5: 3-bit pass counter saturates at 7 over 9 passes
    if_c3.in_valid = 1'b1; if_c3.reg_b = 8'd1;
    for (int i = 0; i < 9; i++) begin
      if_c3.reg_a = 8'(i);
      if_c3.inp = 9'(i);
      step();
    end
    if_c3.in_valid = 1'b0; if_c3.inp = 9'd9;
    step();
    check("t5_pass_sat", 32'(if_c3.pass_count), 32'd7);
    check("t5_err", 32'(if_c3.err_count), 32'd0);

    // Test 6: latency 3, async reset with vectors in flight
    if_l3.in_valid = 1'b1; if_l3.reg_a = 8'd5; if_l3.reg_b = 8'd6;
    step();
    if_l3.reg_a = 8'd1; if_l3.reg_b = 8'd2;
    step();
    if_l3.reg_a = 8'd3; if_l3.reg_b = 8'd3;
    step();
    if_l3.in_valid = 1'b0; if_l3.inp = 9'd11;
    step();
    check("t6_pass_pre", 32'(if_l3.pass_count), 32'd1);
    if_l3.inp = 9'd3;
    #2 rst_l3 = 1'b1;
    #1;
    check("t6_pass_async", 32'(if_l3.pass_count), 32'd0);
    check("t6_err_async", 32'(if_l3.err_count), 32'd0);
    check("t6_done_async", 32'(if_l3.done), 32'd0);
    step();
    rst_l3 = 1'b0;
    step();
    if_l3.inp = 9'd6;
    step(); step(); step();
    check("t6_pass_post", 32'(if_l3.pass_count), 32'd0);
    check("t6_err_post", 32'(if_l3.err_count), 32'd0);
    check("t6_fv_post", 32'(if_l3.fail_valid), 32'd0);
    if_l3.in_valid = 1'b1; if_l3.stim_done = 1'b1; if_l3.reg_a = 8'd9; if_l3.reg_b = 8'd9; if_l3.inp = 9'd18;
    step();
    if_l3.in_valid = 1'b0; if_l3.stim_done = 1'b0;
    step(); step();
    check("t6_done_before", 32'(if_l3.done), 32'd0);
    step();
    check("t6_restart_pass", 32'(if_l3.pass_count), 32'd1);
    step();
    check("t6_restart_done", 32'(if_l3.done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
